// File: rtl/cv32e40p_pkg.sv
// Shared types for the CV32E40P front-end slice.
// Latency: none (types only).
// Backpressure: not applicable.
package cv32e40p_pkg;

  // One fetched instruction as handed from IF to ID.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compressed;
    logic        illegal_c;
    logic        fetch_failed;
  } if_id_entry_t;

endpackage

// File: rtl/cv32e40p_if_id_queue.sv
// IF-to-ID decoupling queue with optional empty-queue bypass.
// Latency: 1 cycle push-to-output; 0 cycles when PASSTHROUGH bypass applies.
// Backpressure: in_ready_o = (count_o < DEPTH), never combinational on out_ready_i.
module cv32e40p_if_id_queue
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter bit          PASSTHROUGH = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_instr_i,
  input  logic [31:0]                  in_pc_i,
  input  logic                         in_compressed_i,
  input  logic                         in_illegal_c_i,
  input  logic                         in_fetch_failed_i,
  input  logic                         halt_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_instr_o,
  output logic [31:0]                  out_pc_o,
  output logic                         out_compressed_o,
  output logic                         out_illegal_c_o,
  output logic                         out_fetch_failed_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]  count_q;
  logic [PW-1:0]  rptr_q;
  logic [PW-1:0]  wptr_q;
  logic [DEPTH-1:0] written_q;
  if_id_entry_t   mem_q [DEPTH];

  if_id_entry_t   in_entry;
  if_id_entry_t   head;
  if_id_entry_t   out_entry;
  logic           bypass;
  logic           push;
  logic           pop;

  // Mod-DEPTH pointer increment; works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_entry = '{instr:        in_instr_i,
                      pc:           in_pc_i,
                      compressed:   in_compressed_i,
                      illegal_c:    in_illegal_c_i,
                      fetch_failed: in_fetch_failed_i};

  // Head slot; a slot never written since reset reads as zero, so payload
  // storage itself needs no reset and stale pre-reset data never leaks out.
  always_comb begin
    head = '0;
    if (written_q[rptr_q]) head = mem_q[rptr_q];
  end

  // Bypass only when empty and ID may see the entry this cycle; rst_n gates it
  // so the outputs sit at zero for the whole reset assertion.
  assign bypass = PASSTHROUGH && rst_n && (count_q == '0) && in_valid_i &&
                  !halt_i && !flush_i;

  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = ((count_q != '0) && !halt_i && !flush_i) || bypass;
  assign count_o     = count_q;
  assign busy_o      = (count_q != '0);

  // A bypassed entry consumed by ID in the same cycle is not stored.
  assign push = in_valid_i && in_ready_o && !flush_i && !(bypass && out_ready_i);
  assign pop  = out_valid_o && out_ready_i && !bypass;

  // Output mux between the live input (bypass) and the stored head.
  always_comb begin
    out_entry = head;
    if (bypass) out_entry = in_entry;
  end

  assign out_instr_o        = out_entry.instr;
  assign out_pc_o           = out_entry.pc;
  assign out_compressed_o   = out_entry.compressed;
  assign out_illegal_c_o    = out_entry.illegal_c;
  assign out_fetch_failed_o = out_entry.fetch_failed;

  // Occupancy, pointers and written-slot flags; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      written_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      if (push) begin
        wptr_q            <= ptr_inc(wptr_q);
        written_q[wptr_q] <= 1'b1;
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// Directed bench for the IF-to-ID queue: three instances share stimulus,
// index 0 = DEPTH 2 / no bypass, 1 = DEPTH 2 / bypass, 2 = DEPTH 3 / no bypass.
// Each step checks only the instance the step targets.
module tb_cv32e40p_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, in_valid_i, halt_i, out_ready_i;
  logic [31:0] in_instr_i, in_pc_i;
  logic        in_cmp, in_ill, in_ff;

  logic        o_ready [3];
  logic        o_valid [3];
  logic [31:0] o_instr [3];
  logic [31:0] o_pc    [3];
  logic        o_cmp   [3];
  logic        o_ill   [3];
  logic        o_ff    [3];
  logic [1:0]  o_count [3];
  logic        o_busy  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cv32e40p_if_id_queue #(
      .DEPTH       ((g == 2) ? 3 : 2),
      .PASSTHROUGH (g == 1)
    ) u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush_i            (flush_i),
      .in_valid_i         (in_valid_i),
      .in_ready_o         (o_ready[g]),
      .in_instr_i         (in_instr_i),
      .in_pc_i            (in_pc_i),
      .in_compressed_i    (in_cmp),
      .in_illegal_c_i     (in_ill),
      .in_fetch_failed_i  (in_ff),
      .halt_i             (halt_i),
      .out_valid_o        (o_valid[g]),
      .out_ready_i        (out_ready_i),
      .out_instr_o        (o_instr[g]),
      .out_pc_o           (o_pc[g]),
      .out_compressed_o   (o_cmp[g]),
      .out_illegal_c_o    (o_ill[g]),
      .out_fetch_failed_o (o_ff[g]),
      .count_o            (o_count[g]),
      .busy_o             (o_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid_i = v;
    in_pc_i    = pc;
    in_instr_i = pc + 32'h1000_0000;
  endtask

  task automatic clear_inputs();
    flush_i = 0; halt_i = 0; out_ready_i = 0;
    in_cmp = 0; in_ill = 0; in_ff = 0;
    drive(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    rst_n = 1;
  endtask

  function automatic logic [31:0] flags(input int g);
    return {29'd0, o_cmp[g], o_ill[g], o_ff[g]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, popped, mdl;
    logic push_e, pop_e;

    // ---- reset values
    rst_n = 0;
    clear_inputs();
    #3;
    chk("rst_valid", o_valid[0], 0);
    chk("rst_ready", o_ready[0], 1);
    chk("rst_count", o_count[0], 0);
    chk("rst_busy",  o_busy[0],  0);
    chk("rst_pc",    o_pc[0],    0);
    chk("rst_instr", o_instr[0], 0);
    chk("rst_flags", flags(0),   0);
    tick();
    rst_n = 1;

    // ---- fill DEPTH 2, then drain while the third entry takes the freed slot
    drive(1, 32'h100);
    #1 chk("fill_rdy0", o_ready[0], 1);
    tick(); drive(1, 32'h104);
    #1 chk("fill_cnt1", o_count[0], 1);
    chk("fill_vld1", o_valid[0], 1);
    chk("fill_pc1",  o_pc[0], 32'h100);
    chk("fill_instr1", o_instr[0], 32'h1000_0100);
    tick(); drive(1, 32'h108);
    #1 chk("full_rdy", o_ready[0], 0);
    chk("full_cnt", o_count[0], 2);
    tick();
    out_ready_i = 1;
    #1 chk("full_cnt_hold", o_count[0], 2);
    chk("full_pop_rdy", o_ready[0], 0);
    chk("drain_pc0", o_pc[0], 32'h100);
    tick();
    #1 chk("drain_rdy", o_ready[0], 1);
    chk("drain_pc1", o_pc[0], 32'h104);
    tick(); drive(0, 32'h0);
    #1 chk("drain_cnt", o_count[0], 1);
    chk("drain_pc2", o_pc[0], 32'h108);
    tick();
    #1 chk("drain_empty", o_count[0], 0);
    chk("drain_busy", o_busy[0], 0);
    chk("drain_vld", o_valid[0], 0);

    // ---- bypass on the PASSTHROUGH instance
    do_reset();
    drive(1, 32'h200); out_ready_i = 1;
    #1 chk("byp_vld", o_valid[1], 1);
    chk("byp_pc",  o_pc[1], 32'h200);
    chk("byp_cnt", o_count[1], 0);
    tick(); drive(0, 32'h0);
    #1 chk("byp_cnt_after", o_count[1], 0);
    chk("byp_vld_after", o_valid[1], 0);
    drive(1, 32'h204); out_ready_i = 0;
    #1 chk("byp_stall_pc", o_pc[1], 32'h204);
    tick(); drive(0, 32'h0);
    #1 chk("byp_stored_cnt", o_count[1], 1);
    chk("byp_stored_pc", o_pc[1], 32'h204);

    // ---- flush with a concurrent push
    do_reset();
    drive(1, 32'h10);
    tick(); drive(1, 32'h14);
    tick();
    flush_i = 1; out_ready_i = 1; drive(1, 32'h300);
    #1 chk("flush_vld", o_valid[0], 0);
    tick();
    flush_i = 0; out_ready_i = 0; drive(0, 32'h0);
    #1 chk("flush_cnt", o_count[0], 0);
    chk("flush_vld_next", o_valid[0], 0);
    chk("flush_head", o_pc[0], 32'h10);
    drive(1, 32'h40);
    tick(); drive(0, 32'h0);
    #1 chk("flush_repush_pc", o_pc[0], 32'h40);
    chk("flush_repush_cnt", o_count[0], 1);

    // ---- DEPTH 3, ten pushes, random consumer
    do_reset();
    pushed = 0; popped = 0; mdl = 0;
    for (int cyc = 0; cyc < 400 && popped < 10; cyc++) begin
      drive(pushed < 10, 32'(pushed * 4));
      out_ready_i = 1'($urandom_range(0, 1));
      #1;
      chk("d3_cnt", o_count[2], 32'(mdl));
      chk("d3_rdy", o_ready[2], (mdl < 3) ? 1 : 0);
      chk("d3_vld", o_valid[2], (mdl != 0) ? 1 : 0);
      pop_e  = (mdl != 0) && out_ready_i;
      push_e = in_valid_i && (mdl < 3);
      if (pop_e) chk("d3_pc", o_pc[2], 32'(popped * 4));
      tick();
      mdl    = mdl + int'(push_e) - int'(pop_e);
      pushed = pushed + int'(push_e);
      popped = popped + int'(pop_e);
    end
    chk("d3_all_out", 32'(popped), 10);

    // ---- halt blocks delivery but not pushes
    do_reset();
    drive(1, 32'h500); in_ff = 1;
    tick();
    halt_i = 1; in_ff = 0; drive(1, 32'h504);
    #1 chk("halt_vld", o_valid[0], 0);
    chk("halt_rdy", o_ready[0], 1);
    tick(); drive(0, 32'h0);
    #1 chk("halt_cnt", o_count[0], 2);
    halt_i = 0;
    #1 chk("unhalt_vld", o_valid[0], 1);
    chk("unhalt_ff", flags(0), 1);
    chk("unhalt_pc", o_pc[0], 32'h500);

    // ---- asynchronous reset mid-stream with two entries held
    #2 rst_n = 0;
    #1 chk("arst_cnt",   o_count[0], 0);
    chk("arst_vld",   o_valid[0], 0);
    chk("arst_rdy",   o_ready[0], 1);
    chk("arst_busy",  o_busy[0],  0);
    chk("arst_pc",    o_pc[0],    0);
    chk("arst_instr", o_instr[0], 0);
    chk("arst_flags", flags(0),   0);
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_pc",  o_pc[0],    0);
    chk("post_rst_vld", o_valid[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
